// File: rtl/thermal_guard_pkg.sv
// ---------------------------------------------------------------------------
// thermal_guard_pkg
//
// Shared definitions for the thermal shut-off guard:
//   - chan_state_t : per-channel FSM state (COOL, SHUT)
//   - DEF_*        : default parameter values used by the guard modules
//   - MAX_NCH      : widest trip-event vector the popcount helper accepts
//   - popcount()   : number of set bits in a trip-event vector
// ---------------------------------------------------------------------------
package thermal_guard_pkg;

    // A channel is either passing power (COOL) or commanding shut-off (SHUT).
    typedef enum logic {
        COOL = 1'b0,
        SHUT = 1'b1
    } chan_state_t;

    localparam int DEF_NCH         = 4;
    localparam int DEF_TRIP_CYCLES = 4;
    localparam int DEF_COOL_CYCLES = 8;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_TOT_W       = 8;

    // Upper bound on the channel count; the top zero-extends its event
    // vector to this width before counting, so NCH must not exceed it.
    localparam int MAX_NCH = 64;

    // Counts how many channels raised a trip event in the current cycle.
    function automatic int unsigned popcount(input logic [MAX_NCH-1:0] vec);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_NCH; i++) begin
            n += 32'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/thermal_guard_chan.sv
// ---------------------------------------------------------------------------
// thermal_guard_chan
//
// One guard channel: debounces the overheat input before tripping, holds the
// shut-off through a cool-down window, and keeps a sticky trip flag.
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset (COOL, counter 0, flag 0)
//   overheated : overheat indication for this channel, sampled every cycle
//   clr_flag   : clears the sticky trip flag (a simultaneous trip wins)
//   shut_off   : registered shut-off command
//   trip_flag  : sticky, set when the channel trips, cleared by clr_flag
//   trip_event : single-cycle pulse, high in the cycle whose edge trips
// ---------------------------------------------------------------------------
module thermal_guard_chan
    import thermal_guard_pkg::*;
#(
    parameter int TRIP_CYCLES = DEF_TRIP_CYCLES,
    parameter int COOL_CYCLES = DEF_COOL_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic overheated,
    input  logic clr_flag,
    output logic shut_off,
    output logic trip_flag,
    output logic trip_event
);

    localparam logic [CNT_W-1:0] TRIP_LAST = CNT_W'(TRIP_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOL_CYCLES - 1);

    chan_state_t       state;
    chan_state_t       state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              flag_next;

    // State, run counter and sticky flag all live here; reset drops any
    // partially counted run so nothing survives a mid-operation reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COOL;
            cnt       <= '0;
            trip_flag <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            trip_flag <= flag_next;
        end
    end

    // The counter measures the current run of samples that argue for
    // leaving the present state; any opposing sample restarts it. The
    // transition happens on the edge that samples the last sample of the
    // run, so the counter compares against CYCLES-1.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        trip_event = 1'b0;
        case (state)
            COOL: begin
                if (overheated) begin
                    if (cnt == TRIP_LAST) begin
                        state_next = SHUT;
                        cnt_next   = '0;
                        trip_event = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end else begin
                    cnt_next = '0;
                end
            end
            SHUT: begin
                if (!overheated) begin
                    if (cnt == COOL_LAST) begin
                        state_next = COOL;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end else begin
                    cnt_next = '0;
                end
            end
            default: begin
                state_next = COOL;
                cnt_next   = '0;
            end
        endcase
    end

    // Clear is applied first so that a trip in the same cycle overrides it.
    always_comb begin
        flag_next = trip_flag;
        if (clr_flag) begin
            flag_next = 1'b0;
        end
        if (trip_event) begin
            flag_next = 1'b1;
        end
    end

    assign shut_off = (state == SHUT);

endmodule

// File: rtl/thermal_shutoff_guard.sv
// ---------------------------------------------------------------------------
// thermal_shutoff_guard
//
// Multi-channel overheat guard placed between the sensor inputs and the
// power-control outputs. Each channel is an independent thermal_guard_chan;
// this level only sums trip events and ORs the shut-off commands.
//
// Ports:
//   clk          : clock, all state updates on the rising edge
//   rst          : synchronous active-high reset
//   overheated   : [NCH] per-channel overheat indication
//   clr_flag     : [NCH] per-channel clear of the sticky trip flag
//   shut_off     : [NCH] per-channel registered shut-off command
//   any_shut_off : OR of shut_off
//   trip_flag    : [NCH] per-channel sticky trip flag
//   trip_total   : [TOT_W] saturating count of trip events, all channels
// ---------------------------------------------------------------------------
module thermal_shutoff_guard
    import thermal_guard_pkg::*;
#(
    parameter int NCH         = DEF_NCH,
    parameter int TRIP_CYCLES = DEF_TRIP_CYCLES,
    parameter int COOL_CYCLES = DEF_COOL_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TOT_W       = DEF_TOT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   overheated,
    input  logic [NCH-1:0]   clr_flag,
    output logic [NCH-1:0]   shut_off,
    output logic             any_shut_off,
    output logic [NCH-1:0]   trip_flag,
    output logic [TOT_W-1:0] trip_total
);

    localparam logic [TOT_W:0]   TOT_MAX = {1'b0, {TOT_W{1'b1}}};
    localparam logic [TOT_W-1:0] TOT_SAT = {TOT_W{1'b1}};

    logic [NCH-1:0]     trip_event;
    logic [MAX_NCH-1:0] event_vec;
    int unsigned        events;
    logic [TOT_W:0]     events_clamped;
    logic [TOT_W:0]     sum;
    logic [TOT_W-1:0]   total_next;

    // One guard channel per input bit; channels share nothing but the clock
    // and reset.
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        thermal_guard_chan #(
            .TRIP_CYCLES (TRIP_CYCLES),
            .COOL_CYCLES (COOL_CYCLES),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .overheated (overheated[i]),
            .clr_flag   (clr_flag[i]),
            .shut_off   (shut_off[i]),
            .trip_flag  (trip_flag[i]),
            .trip_event (trip_event[i])
        );
    end

    assign any_shut_off = |shut_off;

    assign event_vec = MAX_NCH'(trip_event);
    assign events    = popcount(event_vec);

    // Several channels can trip together, so the increment is a popcount.
    // The increment is first clamped to the counter maximum so the one-bit
    // wider sum cannot overflow even with many channels, then the sum is
    // clamped so the total sticks at its maximum instead of wrapping.
    always_comb begin
        if (events >= 32'(TOT_MAX)) begin
            events_clamped = TOT_MAX;
        end else begin
            events_clamped = (TOT_W + 1)'(events);
        end
        sum = {1'b0, trip_total} + events_clamped;
        if (sum > TOT_MAX) begin
            total_next = TOT_SAT;
        end else begin
            total_next = sum[TOT_W-1:0];
        end
    end

    // Global trip accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            trip_total <= '0;
        end else begin
            trip_total <= total_next;
        end
    end

endmodule

// File: tb/tb_thermal_shutoff_guard.sv
// ---------------------------------------------------------------------------
// tb_thermal_shutoff_guard
//
// Directed bench for thermal_shutoff_guard. The main instance uses the
// default parameters; a second instance with TOT_W=2 and one-cycle trip and
// cool windows exercises counter saturation and the shortest latency.
// ---------------------------------------------------------------------------
module tb_thermal_shutoff_guard;

    logic       clk;
    logic       rst;

    logic [3:0] overheated;
    logic [3:0] clr_flag;
    logic [3:0] shut_off;
    logic       any_shut_off;
    logic [3:0] trip_flag;
    logic [7:0] trip_total;

    logic [3:0] sat_overheated;
    logic [3:0] sat_clr_flag;
    logic [3:0] sat_shut_off;
    logic       sat_any_shut_off;
    logic [3:0] sat_trip_flag;
    logic [1:0] sat_trip_total;

    int total;
    int bad;

    thermal_shutoff_guard #(
        .NCH         (4),
        .TRIP_CYCLES (4),
        .COOL_CYCLES (8),
        .CNT_W       (8),
        .TOT_W       (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .overheated   (overheated),
        .clr_flag     (clr_flag),
        .shut_off     (shut_off),
        .any_shut_off (any_shut_off),
        .trip_flag    (trip_flag),
        .trip_total   (trip_total)
    );

    thermal_shutoff_guard #(
        .NCH         (4),
        .TRIP_CYCLES (1),
        .COOL_CYCLES (1),
        .CNT_W       (8),
        .TOT_W       (2)
    ) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .overheated   (sat_overheated),
        .clr_flag     (sat_clr_flag),
        .shut_off     (sat_shut_off),
        .any_shut_off (sat_any_shut_off),
        .trip_flag    (sat_trip_flag),
        .trip_total   (sat_trip_total)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Drive the main instance inputs, let one rising edge sample them, and
    // return 1 time unit after that edge so outputs are read settled.
    task automatic applyStimulus(input logic [3:0] oh, input logic [3:0] clr);
        overheated = oh;
        clr_flag   = clr;
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        clk            = 1'b0;
        rst            = 1'b1;
        overheated     = 4'b0000;
        clr_flag       = 4'b0000;
        sat_overheated = 4'b0000;
        sat_clr_flag   = 4'b0000;

        // ---- reset ----
        applyStimulus(4'b0000, 4'b0000);
        rst = 1'b0;
        checkOutput("rst_shut_off", 32'(shut_off), 32'h0);
        checkOutput("rst_trip_flag", 32'(trip_flag), 32'h0);
        checkOutput("rst_trip_total", 32'(trip_total), 32'h0);
        checkOutput("rst_any_shut_off", 32'(any_shut_off), 32'h0);
        checkOutput("rst_sat_total", 32'(sat_trip_total), 32'h0);

        // ---- debounce: 3 high, 1 low, then 4 high ----
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0001, 4'b0000);
            checkOutput("deb_burst1_shut", 32'(shut_off), 32'h0);
        end
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("deb_gap_shut", 32'(shut_off), 32'h0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0001, 4'b0000);
            checkOutput("deb_burst2_shut", 32'(shut_off), 32'h0);
        end
        applyStimulus(4'b0001, 4'b0000);
        checkOutput("deb_trip_shut", 32'(shut_off), 32'h1);
        checkOutput("deb_trip_flag", 32'(trip_flag), 32'h1);
        checkOutput("deb_trip_total", 32'(trip_total), 32'd1);
        checkOutput("deb_trip_any", 32'(any_shut_off), 32'h1);

        // ---- hysteresis: 5 low, 1 high, 8 low ----
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b0000, 4'b0000);
            checkOutput("hys_low5_shut", 32'(shut_off), 32'h1);
        end
        applyStimulus(4'b0001, 4'b0000);
        checkOutput("hys_reheat_shut", 32'(shut_off), 32'h1);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(4'b0000, 4'b0000);
            checkOutput("hys_low7_shut", 32'(shut_off), 32'h1);
        end
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("hys_release_shut", 32'(shut_off), 32'h0);
        checkOutput("hys_release_any", 32'(any_shut_off), 32'h0);
        checkOutput("hys_total", 32'(trip_total), 32'd1);
        checkOutput("hys_flag_sticky", 32'(trip_flag), 32'h1);

        // ---- clear flag of channel 0 while cool ----
        applyStimulus(4'b0000, 4'b0001);
        checkOutput("clr0_flag", 32'(trip_flag), 32'h0);

        // ---- simultaneous trips on channels 0, 1, 3 ----
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b1011, 4'b0000);
            checkOutput("sim_pre_shut", 32'(shut_off), 32'h0);
        end
        applyStimulus(4'b1011, 4'b0000);
        checkOutput("sim_trip_shut", 32'(shut_off), 32'hB);
        checkOutput("sim_trip_total", 32'(trip_total), 32'd4);
        checkOutput("sim_trip_any", 32'(any_shut_off), 32'h1);
        checkOutput("sim_trip_flag", 32'(trip_flag), 32'hB);

        // ---- flag clear race on channel 2 ----
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b1111, 4'b0000);
            checkOutput("race_pre_shut", 32'(shut_off), 32'hB);
        end
        applyStimulus(4'b1111, 4'b0100);
        checkOutput("race_trip_shut", 32'(shut_off), 32'hF);
        checkOutput("race_set_wins_flag", 32'(trip_flag), 32'hF);
        checkOutput("race_trip_total", 32'(trip_total), 32'd5);
        applyStimulus(4'b1111, 4'b0100);
        checkOutput("race_clear_flag", 32'(trip_flag), 32'hB);
        checkOutput("race_clear_shut", 32'(shut_off), 32'hF);
        checkOutput("race_clear_total", 32'(trip_total), 32'd5);

        // ---- reset mid-operation: channel 1 has 6 cool samples ----
        for (int k = 0; k < 6; k++) begin
            applyStimulus(4'b1101, 4'b0000);
            checkOutput("mid_cool_shut", 32'(shut_off), 32'hF);
        end
        rst = 1'b1;
        applyStimulus(4'b0010, 4'b0000);
        rst = 1'b0;
        checkOutput("mid_rst_shut", 32'(shut_off), 32'h0);
        checkOutput("mid_rst_flag", 32'(trip_flag), 32'h0);
        checkOutput("mid_rst_total", 32'(trip_total), 32'h0);
        checkOutput("mid_rst_any", 32'(any_shut_off), 32'h0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0010, 4'b0000);
            checkOutput("post_rst_no_trip", 32'(shut_off), 32'h0);
        end
        applyStimulus(4'b0010, 4'b0000);
        checkOutput("post_rst_trip_shut", 32'(shut_off), 32'h2);
        checkOutput("post_rst_trip_total", 32'(trip_total), 32'd1);

        // ---- saturation instance: five separate one-cycle trips ----
        sat_overheated = 4'b0001;
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("sat_latency_shut", 32'(sat_shut_off), 32'h1);
        checkOutput("sat_total_1", 32'(sat_trip_total), 32'd1);
        sat_overheated = 4'b0000;
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("sat_release_shut", 32'(sat_shut_off), 32'h0);
        sat_overheated = 4'b0001;
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("sat_total_2", 32'(sat_trip_total), 32'd2);
        sat_overheated = 4'b0000;
        applyStimulus(4'b0000, 4'b0000);
        sat_overheated = 4'b0001;
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("sat_total_3", 32'(sat_trip_total), 32'd3);
        sat_overheated = 4'b0000;
        applyStimulus(4'b0000, 4'b0000);
        sat_overheated = 4'b0001;
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("sat_total_4", 32'(sat_trip_total), 32'd3);
        sat_overheated = 4'b0000;
        applyStimulus(4'b0000, 4'b0000);
        sat_overheated = 4'b0001;
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("sat_total_5", 32'(sat_trip_total), 32'd3);
        sat_overheated = 4'b0000;
        applyStimulus(4'b0000, 4'b0000);
        sat_overheated = 4'b1111;
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("sat_multi_total", 32'(sat_trip_total), 32'd3);
        checkOutput("sat_multi_shut", 32'(sat_shut_off), 32'hF);
        sat_overheated = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
